// File: rtl/exec_stage.sv
// Execute stage of the 16-bit CPU: one combinational ALU behind a two-entry
// elastic buffer (main + skid), plus the architectural NZCV flags and branch-condition evaluation.

module exec_alu #(
    parameter int DW = 16
) (
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] r_o,
    output logic [3:0]    nzcv_o
);
    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;
    logic [3:0]    shamt_w;
    logic          c_w;
    logic          v_w;

    assign shamt_w = b_i[3:0];
    assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
    assign dif_w   = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        r_o = '0;
        c_w = 1'b0;
        v_w = 1'b0;
        case (op_i)
            3'b000: begin
                r_o = sum_w[DW-1:0];
                c_w = sum_w[DW];
                v_w = (a_i[DW-1] == b_i[DW-1]) && (sum_w[DW-1] != a_i[DW-1]);
            end
            3'b001: begin
                // Carry is NOT borrow: set when a >= b unsigned.
                r_o = dif_w[DW-1:0];
                c_w = ~dif_w[DW];
                v_w = (a_i[DW-1] != b_i[DW-1]) && (dif_w[DW-1] != a_i[DW-1]);
            end
            3'b010: r_o = a_i & b_i;
            3'b011: r_o = a_i | b_i;
            3'b100: r_o = ~(a_i | b_i);
            3'b101: r_o = a_i << shamt_w;
            3'b110: r_o = a_i >> shamt_w;
            default: r_o = $unsigned($signed(a_i) >>> shamt_w);
        endcase
    end

    assign nzcv_o = {r_o[DW-1], (r_o == '0), c_w, v_w};
endmodule

module exec_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          in_setf,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic [3:0]    flags,
    input  logic [2:0]    cond,
    output logic          cond_true,
    output logic [1:0]    occupancy
);
    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_r_q,     main_r_d;
    logic [RW-1:0] main_rd_q,    main_rd_d;
    logic          main_we_q,    main_we_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_r_q,     skid_r_d;
    logic [RW-1:0] skid_rd_q,    skid_rd_d;
    logic          skid_we_q,    skid_we_d;
    logic [3:0]    flags_q,      flags_d;

    logic [DW-1:0] alu_r;
    logic [3:0]    alu_nzcv;
    logic          acc;

    exec_alu #(.DW(DW)) u_alu (
        .op_i   (in_op),
        .a_i    (in_a),
        .b_i    (in_b),
        .r_o    (alu_r),
        .nzcv_o (alu_nzcv)
    );

    // Handshake: a transfer happens on a side when valid & ready are both high at the
    // rising edge; in_ready looks only at registered skid state and flush, never out_ready.
    assign in_ready = ~skid_valid_q & ~flush;
    assign acc      = in_valid & in_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_r_d     = main_r_q;
        main_rd_d    = main_rd_q;
        main_we_d    = main_we_q;
        skid_valid_d = skid_valid_q;
        skid_r_d     = skid_r_q;
        skid_rd_d    = skid_rd_q;
        skid_we_d    = skid_we_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_ready && main_valid_q && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_r_d     = skid_r_q;
            main_rd_d    = skid_rd_q;
            main_we_d    = skid_we_q;
            skid_valid_d = 1'b0;
        end else if (acc && (!main_valid_q || out_ready)) begin
            main_valid_d = 1'b1;
            main_r_d     = alu_r;
            main_rd_d    = in_rd;
            main_we_d    = in_we;
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_r_d     = alu_r;
            skid_rd_d    = in_rd;
            skid_we_d    = in_we;
        end else if (out_ready && main_valid_q) begin
            main_valid_d = 1'b0;
        end
    end

    // Flags commit at accept and survive a later flush of the buffered result.
    assign flags_d = (acc && in_setf) ? alu_nzcv : flags_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_r_q     <= '0;
            main_rd_q    <= '0;
            main_we_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_r_q     <= '0;
            skid_rd_q    <= '0;
            skid_we_q    <= 1'b0;
            flags_q      <= 4'b0000;
        end else begin
            main_valid_q <= main_valid_d;
            main_r_q     <= main_r_d;
            main_rd_q    <= main_rd_d;
            main_we_q    <= main_we_d;
            skid_valid_q <= skid_valid_d;
            skid_r_q     <= skid_r_d;
            skid_rd_q    <= skid_rd_d;
            skid_we_q    <= skid_we_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_r     = main_r_q;
    assign out_rd    = main_rd_q;
    assign out_we    = main_we_q;
    assign flags     = flags_q;
    assign occupancy = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags_q[2];
            3'b010: cond_true = ~flags_q[2];
            3'b011: cond_true = flags_q[3] ^ flags_q[0];
            3'b100: cond_true = ~(flags_q[3] ^ flags_q[0]);
            3'b101: cond_true = flags_q[1];
            3'b110: cond_true = ~flags_q[1];
            default: cond_true = flags_q[3];
        endcase
    end
endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage: hand-computed results, flags, buffering and flush/reset.

module tb_exec_stage;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        in_setf;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic [2:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        cond_true;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                           OP_NOR = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_SRA = 3'b111;

    exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_setf   (in_setf),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true),
        .occupancy (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rd, input logic setf);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_we    = 1'b1;
        in_setf  = setf;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_setf  = 1'b0;
    endtask

    logic [15:0] stream_a[4];
    logic [15:0] stream_b[4];
    logic [2:0]  stream_op[4];
    logic [15:0] stream_r[4];
    logic        fire_in;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        in_we = 1'b0; in_setf = 1'b0; flush = 1'b0; out_ready = 1'b0; cond = 3'b000;
        #1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_we", out_we, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_occupancy", occupancy, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // 1: ADD overflow into sign bit
        out_ready = 1'b1;
        drive(OP_ADD, 16'h7FFF, 16'h0001, 3'd3, 1'b1);
        #1 check("t1_in_ready", in_ready, 1);
        tick();
        idle();
        cond = 3'b011;
        #1;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_r", out_r, 16'h8000);
        check("t1_out_rd", out_rd, 3'd3);
        check("t1_out_we", out_we, 1);
        check("t1_flags", flags, 4'b1001);
        check("t1_lt_false", cond_true, 0);

        // 2: SUB borrow, then SUB equal
        drive(OP_SUB, 16'h0000, 16'h0001, 3'd1, 1'b1);
        tick();
        check("t2a_out_r", out_r, 16'hFFFF);
        check("t2a_flags", flags, 4'b1000);
        check("t2a_occupancy", occupancy, 1);
        drive(OP_SUB, 16'h0003, 16'h0003, 3'd2, 1'b1);
        tick();
        idle();
        cond = 3'b001;
        #1;
        check("t2b_out_r", out_r, 16'h0000);
        check("t2b_flags", flags, 4'b0110);
        check("t2b_eq_true", cond_true, 1);
        cond = 3'b101;
        #1 check("t2b_cs_true", cond_true, 1);
        tick();
        check("t2_drained", occupancy, 0);

        // 4: SRA without setf leaves flags alone
        drive(OP_SRA, 16'h8000, 16'h0001, 3'd4, 1'b0);
        tick();
        idle();
        check("t4_out_r", out_r, 16'hC000);
        check("t4_flags", flags, 4'b0110);
        tick();

        // 3: backpressure with three back-to-back ops
        out_ready = 1'b0;
        drive(OP_AND, 16'h00FF, 16'h0F0F, 3'd5, 1'b0);
        tick();
        drive(OP_OR, 16'h00FF, 16'h0F0F, 3'd6, 1'b0);
        #1 check("t3_in_ready_2nd", in_ready, 1);
        tick();
        drive(OP_SLL, 16'h0001, 16'h0004, 3'd7, 1'b0);
        #1;
        check("t3_occupancy", occupancy, 2);
        check("t3_in_ready_3rd", in_ready, 0);
        tick();
        check("t3_hold_r", out_r, 16'h000F);
        check("t3_hold_rd", out_rd, 3'd5);
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h0FFF);
        exp_q.push_back(16'h0010);
        out_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
            if (out_valid) check("t3_seq", out_r, exp_q.pop_front());
            fire_in = in_valid & in_ready;
            tick();
            if (fire_in) idle();
        end
        check("t3_all_received", exp_q.size(), 0);
        check("t3_empty", out_valid, 0);

        // 5: flush with two buffered ops and a pending op
        out_ready = 1'b0;
        drive(OP_ADD, 16'h8000, 16'h8000, 3'd1, 1'b1);
        tick();
        drive(OP_OR, 16'h0001, 16'h0002, 3'd2, 1'b0);
        tick();
        check("t5_occupancy", occupancy, 2);
        check("t5_flags_pre", flags, 4'b0111);
        drive(OP_ADD, 16'h0001, 16'h0001, 3'd3, 1'b1);
        flush = 1'b1;
        out_ready = 1'b1;
        #1 check("t5_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_occupancy_post", occupancy, 0);
        check("t5_flags_post", flags, 4'b0111);
        check("t5_in_ready_post", in_ready, 1);

        // 6: reset mid-stream, then full-rate streaming
        out_ready = 1'b0;
        drive(OP_SUB, 16'h0005, 16'h0003, 3'd4, 1'b1);
        tick();
        drive(OP_SUB, 16'h0005, 16'h0003, 3'd5, 1'b1);
        tick();
        idle();
        check("t6_occupancy", occupancy, 2);
        check("t6_flags_pre", flags, 4'b0010);
        rst_n = 1'b0;
        tick();
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_r", out_r, 0);
        check("t6_rst_out_rd", out_rd, 0);
        check("t6_rst_out_we", out_we, 0);
        check("t6_rst_flags", flags, 4'b0000);
        check("t6_rst_occupancy", occupancy, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stream_op[0] = OP_NOR; stream_a[0] = 16'h0000; stream_b[0] = 16'h00FF; stream_r[0] = 16'hFF00;
        stream_op[1] = OP_SRL; stream_a[1] = 16'h8000; stream_b[1] = 16'h000F; stream_r[1] = 16'h0001;
        stream_op[2] = OP_ADD; stream_a[2] = 16'h1234; stream_b[2] = 16'h1111; stream_r[2] = 16'h2345;
        stream_op[3] = OP_SUB; stream_a[3] = 16'h0010; stream_b[3] = 16'h0001; stream_r[3] = 16'h000F;
        for (int i = 0; i < 4; i++) begin
            drive(stream_op[i], stream_a[i], stream_b[i], 3'(i), 1'b0);
            #1 check("t6_stream_ready", in_ready, 1);
            tick();
            check("t6_stream_valid", out_valid, 1);
            check("t6_stream_r", out_r, stream_r[i]);
        end
        idle();
        tick();
        check("t6_drained", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
